dm_access_unit: RTL and testbench

MEM-stage data-memory access sequencer, directly upstream of the load controller. Takes the MEM-stage request (valid, rd/wr, size, address, store data) and runs a req/ack transaction to data memory. It stalls the pipeline for the whole transaction. It presents the captured 64-bit doubleword as dm_data together with the mem-staller flag. Stores get byte enables, shifted write data and misalignment rejection here; load-side alignment and extraction stay downstream.

---
 rtl/dm_access_unit_if.sv | 23 ++
 rtl/dm_access_unit.sv | 148 ++++++++++++++
 tb/tb_dm_access_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access unit and data memory.
// The access unit is the master; the memory (or a bench model of it) is the slave.
interface dm_access_unit_if #(
  parameter int ADDR_W = 64
);
  logic              o_dm_req;
  logic              o_dm_we;
  logic [ADDR_W-1:0] o_dm_addr;
  logic [63:0]       o_dm_wdata;
  logic [7:0]        o_dm_be;
  logic              i_dm_ack;
  logic [63:0]       i_dm_rdata;

  modport master (
    output o_dm_req, o_dm_we, o_dm_addr, o_dm_wdata, o_dm_be,
    input  i_dm_ack, i_dm_rdata
  );

  modport slave (
    input  o_dm_req, o_dm_we, o_dm_addr, o_dm_wdata, o_dm_be,
    output i_dm_ack, i_dm_rdata
  );
endinterface

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access sequencer: issues one req/ack transaction per load or store,
// stalls the pipeline while it runs and hands the captured doubleword to the load controller.
module dm_access_unit #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [1:0]        i_mem_req_unit,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [63:0]       i_store_data,
  input  logic              i_flush,
  dm_access_unit_if.master  dm,
  output logic [63:0]       o_dm_data,
  output logic              o_is_mem_staller,
  output logic              o_store_misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        be_q, be_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       data_q, data_d;
  logic              mis_q, mis_d;

  logic [2:0]  off;
  logic        isStore;
  logic        misaligned;
  logic        stMis;
  logic        start;
  logic [7:0]  storeBe;
  logic [63:0] storeData;

  assign off     = i_mem_addr[2:0];
  // A load wins if both rd and wr are raised, so only a pure write counts as a store.
  assign isStore = i_mem_wr & ~i_mem_rd;

  always_comb begin
    misaligned = 1'b0;
    storeBe    = 8'hFF;
    case (i_mem_req_unit)
      2'd0: begin
        misaligned = 1'b0;
        storeBe    = 8'h01 << off;
      end
      2'd1: begin
        misaligned = (off == 3'd7);
        storeBe    = 8'h03 << off;
      end
      2'd2: begin
        misaligned = (off > 3'd4);
        storeBe    = 8'h0F << off;
      end
      default: begin
        misaligned = (off != 3'd0);
        storeBe    = 8'hFF;
      end
    endcase
  end

  assign storeData = i_store_data << {off, 3'b000};
  assign stMis     = isStore & misaligned;
  assign start     = (state_q == IDLE) & i_valid & (i_mem_rd | i_mem_wr) & ~i_flush & ~stMis;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        mis_d = i_valid & ~i_flush & stMis;
        if (start) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = isStore;
          addr_d  = {i_mem_addr[ADDR_W-1:3], 3'b000};
          be_d    = isStore ? storeBe : 8'hFF;
          wdata_d = isStore ? storeData : 64'd0;
        end
      end
      BUSY: begin
        // Bus outputs stay frozen until the ack; only a load updates the captured doubleword.
        if (dm.i_dm_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            data_d = dm.i_dm_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 8'd0;
      wdata_q <= 64'd0;
      data_q  <= 64'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
    end
  end

  // Low in DONE so the pipeline advances exactly once per access.
  assign o_is_mem_staller   = start | (state_q == BUSY);

  assign dm.o_dm_req        = req_q;
  assign dm.o_dm_we         = we_q;
  assign dm.o_dm_addr       = addr_q;
  assign dm.o_dm_wdata      = wdata_q;
  assign dm.o_dm_be         = be_q;
  assign o_dm_data          = data_q;
  assign o_store_misaligned = mis_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: inputs change and outputs are sampled on the falling
// edge, with the memory side driven by hand so ack timing is fully controlled.
module tb_dm_access_unit;

  localparam int ADDR_W = 64;

  logic              clk;
  logic              rst;
  logic              i_valid;
  logic              i_mem_rd;
  logic              i_mem_wr;
  logic [1:0]        i_mem_req_unit;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [63:0]       i_store_data;
  logic              i_flush;
  logic [63:0]       o_dm_data;
  logic              o_is_mem_staller;
  logic              o_store_misaligned;

  int checkCount;
  int errorCount;

  dm_access_unit_if #(.ADDR_W(ADDR_W)) dmBus ();

  dm_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_valid            (i_valid),
    .i_mem_rd           (i_mem_rd),
    .i_mem_wr           (i_mem_wr),
    .i_mem_req_unit     (i_mem_req_unit),
    .i_mem_addr         (i_mem_addr),
    .i_store_data       (i_store_data),
    .i_flush            (i_flush),
    .dm                 (dmBus),
    .o_dm_data          (o_dm_data),
    .o_is_mem_staller   (o_is_mem_staller),
    .o_store_misaligned (o_store_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic rd, input logic wr, input logic [1:0] unit,
                               input logic [63:0] addr, input logic [63:0] sdata, input logic flush);
    i_valid        = valid;
    i_mem_rd       = rd;
    i_mem_wr       = wr;
    i_mem_req_unit = unit;
    i_mem_addr     = addr;
    i_store_data   = sdata;
    i_flush        = flush;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic driveAck(input logic ack, input logic [63:0] rdata);
    dmBus.i_dm_ack   = ack;
    dmBus.i_dm_rdata = rdata;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    idleInputs();
    driveAck(1'b0, 64'd0);

    // Reset state
    repeat (2) nextCycle();
    checkOutput("rst_req", {63'd0, dmBus.o_dm_req}, 64'd0);
    checkOutput("rst_we", {63'd0, dmBus.o_dm_we}, 64'd0);
    checkOutput("rst_addr", dmBus.o_dm_addr, 64'd0);
    checkOutput("rst_wdata", dmBus.o_dm_wdata, 64'd0);
    checkOutput("rst_be", {56'd0, dmBus.o_dm_be}, 64'd0);
    checkOutput("rst_data", o_dm_data, 64'd0);
    checkOutput("rst_mis", {63'd0, o_store_misaligned}, 64'd0);
    checkOutput("rst_stall", {63'd0, o_is_mem_staller}, 64'd0);
    rst = 1'b0;
    nextCycle();

    // LD DW at 0x1000, ack in the second BUSY cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 64'h1000, 64'd0, 1'b0);
    #1 checkOutput("ld_start_stall", {63'd0, o_is_mem_staller}, 64'd1);
    checkOutput("ld_start_noreq", {63'd0, dmBus.o_dm_req}, 64'd0);
    nextCycle();
    idleInputs();
    checkOutput("ld_b1_req", {63'd0, dmBus.o_dm_req}, 64'd1);
    checkOutput("ld_b1_addr", dmBus.o_dm_addr, 64'h1000);
    checkOutput("ld_b1_be", {56'd0, dmBus.o_dm_be}, 64'hFF);
    checkOutput("ld_b1_we", {63'd0, dmBus.o_dm_we}, 64'd0);
    checkOutput("ld_b1_stall", {63'd0, o_is_mem_staller}, 64'd1);
    nextCycle();
    checkOutput("ld_b2_req", {63'd0, dmBus.o_dm_req}, 64'd1);
    checkOutput("ld_b2_addr", dmBus.o_dm_addr, 64'h1000);
    checkOutput("ld_b2_be", {56'd0, dmBus.o_dm_be}, 64'hFF);
    checkOutput("ld_b2_stall", {63'd0, o_is_mem_staller}, 64'd1);
    driveAck(1'b1, 64'h1122334455667788);
    nextCycle();
    driveAck(1'b0, 64'd0);
    checkOutput("ld_done_req", {63'd0, dmBus.o_dm_req}, 64'd0);
    checkOutput("ld_done_stall", {63'd0, o_is_mem_staller}, 64'd0);
    checkOutput("ld_done_data", o_dm_data, 64'h1122334455667788);
    nextCycle();

    // SB 0xAB at 0x2005
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 64'h2005, 64'h00000000000000AB, 1'b0);
    #1 checkOutput("sb_start_stall", {63'd0, o_is_mem_staller}, 64'd1);
    nextCycle();
    idleInputs();
    checkOutput("sb_req", {63'd0, dmBus.o_dm_req}, 64'd1);
    checkOutput("sb_we", {63'd0, dmBus.o_dm_we}, 64'd1);
    checkOutput("sb_addr", dmBus.o_dm_addr, 64'h2000);
    checkOutput("sb_be", {56'd0, dmBus.o_dm_be}, 64'h20);
    checkOutput("sb_wdata", dmBus.o_dm_wdata, 64'h0000AB0000000000);
    driveAck(1'b1, 64'hDEADBEEFDEADBEEF);
    nextCycle();
    driveAck(1'b0, 64'd0);
    checkOutput("sb_done_req", {63'd0, dmBus.o_dm_req}, 64'd0);
    checkOutput("sb_data_kept", o_dm_data, 64'h1122334455667788);
    nextCycle();

    // SW at 0x3006 is misaligned: no request, no stall, one-cycle error pulse
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 64'h3006, 64'h00000000CAFEF00D, 1'b0);
    #1 checkOutput("sw_mis_stall", {63'd0, o_is_mem_staller}, 64'd0);
    nextCycle();
    idleInputs();
    checkOutput("sw_mis_pulse", {63'd0, o_store_misaligned}, 64'd1);
    checkOutput("sw_mis_noreq", {63'd0, dmBus.o_dm_req}, 64'd0);
    nextCycle();
    checkOutput("sw_mis_pulse_end", {63'd0, o_store_misaligned}, 64'd0);
    checkOutput("sw_mis_noreq2", {63'd0, dmBus.o_dm_req}, 64'd0);

    // SH at 0x3006 is accepted
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 64'h3006, 64'h000000000000BEEF, 1'b0);
    #1 checkOutput("sh_start_stall", {63'd0, o_is_mem_staller}, 64'd1);
    nextCycle();
    idleInputs();
    checkOutput("sh_req", {63'd0, dmBus.o_dm_req}, 64'd1);
    checkOutput("sh_addr", dmBus.o_dm_addr, 64'h3000);
    checkOutput("sh_be", {56'd0, dmBus.o_dm_be}, 64'hC0);
    checkOutput("sh_wdata", dmBus.o_dm_wdata, 64'hBEEF000000000000);
    checkOutput("sh_nomis", {63'd0, o_store_misaligned}, 64'd0);
    driveAck(1'b1, 64'd0);
    nextCycle();
    driveAck(1'b0, 64'd0);
    nextCycle();

    // LH at 0x4007: misaligned load still goes out as an aligned doubleword read
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 64'h4007, 64'd0, 1'b0);
    nextCycle();
    idleInputs();
    checkOutput("lh_req", {63'd0, dmBus.o_dm_req}, 64'd1);
    checkOutput("lh_addr", dmBus.o_dm_addr, 64'h4000);
    checkOutput("lh_be", {56'd0, dmBus.o_dm_be}, 64'hFF);
    checkOutput("lh_wdata", dmBus.o_dm_wdata, 64'd0);
    checkOutput("lh_nomis", {63'd0, o_store_misaligned}, 64'd0);
    driveAck(1'b1, 64'h0102030405060708);
    nextCycle();
    driveAck(1'b0, 64'd0);
    checkOutput("lh_data", o_dm_data, 64'h0102030405060708);
    nextCycle();

    // Back-to-back loads, ack in the first BUSY cycle, next load presented during DONE
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 64'h5000, 64'd0, 1'b0);
    nextCycle();
    checkOutput("b2b_a_req", {63'd0, dmBus.o_dm_req}, 64'd1);
    checkOutput("b2b_a_addr", dmBus.o_dm_addr, 64'h5000);
    driveAck(1'b1, 64'hAAAAAAAA00000001);
    nextCycle();
    driveAck(1'b0, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 64'h5008, 64'd0, 1'b0);
    #1 checkOutput("b2b_done_stall", {63'd0, o_is_mem_staller}, 64'd0);
    checkOutput("b2b_done_req", {63'd0, dmBus.o_dm_req}, 64'd0);
    checkOutput("b2b_a_data", o_dm_data, 64'hAAAAAAAA00000001);
    nextCycle();
    checkOutput("b2b_gap_req", {63'd0, dmBus.o_dm_req}, 64'd0);
    checkOutput("b2b_b_start_stall", {63'd0, o_is_mem_staller}, 64'd1);
    nextCycle();
    idleInputs();
    checkOutput("b2b_b_req", {63'd0, dmBus.o_dm_req}, 64'd1);
    checkOutput("b2b_b_addr", dmBus.o_dm_addr, 64'h5008);
    driveAck(1'b1, 64'hBBBBBBBB00000002);
    nextCycle();
    driveAck(1'b0, 64'd0);
    checkOutput("b2b_b_data", o_dm_data, 64'hBBBBBBBB00000002);
    checkOutput("b2b_b_done_req", {63'd0, dmBus.o_dm_req}, 64'd0);
    nextCycle();

    // Flush in IDLE suppresses a load and a misaligned-store pulse
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 64'h6000, 64'd0, 1'b1);
    #1 checkOutput("flush_ld_stall", {63'd0, o_is_mem_staller}, 64'd0);
    nextCycle();
    checkOutput("flush_ld_noreq", {63'd0, dmBus.o_dm_req}, 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 64'h6001, 64'd0, 1'b1);
    nextCycle();
    idleInputs();
    checkOutput("flush_st_nomis", {63'd0, o_store_misaligned}, 64'd0);
    checkOutput("flush_st_noreq", {63'd0, dmBus.o_dm_req}, 64'd0);

    // Reset mid-BUSY, then a late ack must be ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 64'h7000, 64'd0, 1'b0);
    nextCycle();
    idleInputs();
    checkOutput("rstb_req", {63'd0, dmBus.o_dm_req}, 64'd1);
    rst = 1'b1;
    nextCycle();
    checkOutput("rstb_req_drop", {63'd0, dmBus.o_dm_req}, 64'd0);
    checkOutput("rstb_data", o_dm_data, 64'd0);
    checkOutput("rstb_stall", {63'd0, o_is_mem_staller}, 64'd0);
    rst = 1'b0;
    driveAck(1'b1, 64'hFFFFFFFFFFFFFFFF);
    nextCycle();
    driveAck(1'b0, 64'd0);
    checkOutput("late_ack_req", {63'd0, dmBus.o_dm_req}, 64'd0);
    checkOutput("late_ack_data", o_dm_data, 64'd0);
    checkOutput("late_ack_stall", {63'd0, o_is_mem_staller}, 64'd0);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
